// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg
//   Shared types and constants for the pe_dot_scheduler slice.
//   - state_t : scheduler FSM states
//   - OPW     : INT8 operand width
//   - ACCW    : accumulator / bias / result width
//   - KW_DEF  : default width of cfg_k and the ifmap address
//   - NW_DEF  : default width of cfg_n, the channel index and the bias address
`timescale 1ns/1ps
package pe_sched_pkg;

  localparam int OPW    = 8;
  localparam int ACCW   = 32;
  localparam int KW_DEF = 10;
  localparam int NW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/pe_sched_addr_gen.sv
// pe_sched_addr_gen
//   Channel/element counters and SRAM read strobes for one dot-product job.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     job_go          start of a job: channel 0, weight address 0
//     ch_go           start of the next channel
//     cfg_k, cfg_n    latched job configuration
//     if_rd/if_addr   ifmap read strobe / address (element index k)
//     w_rd/w_addr     weight read strobe / address (running base + k)
//     b_rd/b_addr     bias read strobe / address (channel index n)
//     issue_last      high while the final element of a channel is issued
//     ch_last         current channel is the last of the job
`timescale 1ns/1ps
module pe_sched_addr_gen
  import pe_sched_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_go,
  input  logic             ch_go,
  input  logic [KW-1:0]    cfg_k,
  input  logic [NW-1:0]    cfg_n,
  output logic             if_rd,
  output logic [KW-1:0]    if_addr,
  output logic             w_rd,
  output logic [KW+NW-1:0] w_addr,
  output logic             b_rd,
  output logic [NW-1:0]    b_addr,
  output logic             issue_last,
  output logic             ch_last
);

  logic             rd_r;
  logic             brd_r;
  logic [KW-1:0]    k_r;
  logic [NW-1:0]    n_r;
  // Weight address register doubles as the running base: it advances once
  // per issued element, so after the last element it already holds base+cfg_k.
  logic [KW+NW-1:0] wa_r;
  logic             issue_last_s;

  assign issue_last_s = rd_r && (k_r == (cfg_k - KW'(1'b1)));

  // Element/channel counters and read-strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r  <= 1'b0;
      brd_r <= 1'b0;
      k_r   <= {KW{1'b0}};
      n_r   <= {NW{1'b0}};
      wa_r  <= {(KW+NW){1'b0}};
    end else if (job_go) begin
      rd_r  <= 1'b1;
      brd_r <= 1'b1;
      k_r   <= {KW{1'b0}};
      n_r   <= {NW{1'b0}};
      wa_r  <= {(KW+NW){1'b0}};
    end else if (ch_go) begin
      rd_r  <= 1'b1;
      brd_r <= 1'b1;
      k_r   <= {KW{1'b0}};
      n_r   <= n_r + NW'(1'b1);
    end else if (rd_r) begin
      brd_r <= 1'b0;
      wa_r  <= wa_r + (KW+NW)'(1'b1);
      if (issue_last_s) begin
        rd_r <= 1'b0;
        k_r  <= {KW{1'b0}};
      end else begin
        k_r  <= k_r + KW'(1'b1);
      end
    end
  end

  assign if_rd      = rd_r;
  assign if_addr    = k_r;
  assign w_rd       = rd_r;
  assign w_addr     = wa_r;
  assign b_rd       = brd_r;
  assign b_addr     = n_r;
  assign issue_last = issue_last_s;
  assign ch_last    = (n_r == (cfg_n - NW'(1'b1)));

endmodule

// File: rtl/pe_dot_scheduler.sv
// pe_dot_scheduler
//   Sequences cfg_n dot products of length cfg_k through one INT8 PE lane:
//   out[n] = sum_k ifmap[k]*weight[n][k] + bias[n].
//   Optional build macro PE_DOT_SCHEDULER_RELU_EN clamps negative results to 0
//   when the channel result is loaded into out_data.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     start, cfg_k, cfg_n      job request and configuration
//     busy, done               job in progress / one-cycle end-of-job pulse
//     if_*, w_*, b_*           ifmap / weight / bias SRAM reads (1-cycle latency)
//     pe_en, pe_ifmap,
//     pe_weight, pe_bias       registered PE operands
//     pe_opsum, pe_valid       PE result
//     out_valid, out_ready,
//     out_data, out_ch         channel result handshake
`timescale 1ns/1ps
module pe_dot_scheduler
  import pe_sched_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          cfg_k,
  input  logic [NW-1:0]          cfg_n,
  output logic                   busy,
  output logic                   done,
  output logic                   if_rd,
  output logic [KW-1:0]          if_addr,
  input  logic signed [OPW-1:0]  if_rdata,
  output logic                   w_rd,
  output logic [KW+NW-1:0]       w_addr,
  input  logic signed [OPW-1:0]  w_rdata,
  output logic                   b_rd,
  output logic [NW-1:0]          b_addr,
  input  logic signed [ACCW-1:0] b_rdata,
  output logic                   pe_en,
  output logic signed [OPW-1:0]  pe_ifmap,
  output logic signed [OPW-1:0]  pe_weight,
  output logic signed [ACCW-1:0] pe_bias,
  input  logic signed [ACCW-1:0] pe_opsum,
  input  logic                   pe_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic [NW-1:0]          out_ch
);

  state_t                 state_r;
  logic [KW-1:0]          cfg_k_r;
  logic [NW-1:0]          cfg_n_r;
  logic                   busy_r, done_r;
  logic                   rd_d_r, brd_d_r;
  logic                   pe_en_r;
  logic signed [OPW-1:0]  pe_ifmap_r, pe_weight_r;
  logic signed [ACCW-1:0] pe_bias_r;
  logic signed [ACCW-1:0] acc_r;
  logic [KW-1:0]          elem_r;
  logic                   out_valid_r;
  logic signed [ACCW-1:0] out_data_r;
  logic [NW-1:0]          out_ch_r;

  logic                   job_go_s, ch_go_s;
  logic                   issue_last_s, ch_last_s;
  logic                   elem_first_s, elem_last_s;
  logic signed [ACCW-1:0] acc_next_s, load_val_s;

  assign job_go_s     = (state_r == IDLE) && start &&
                        (cfg_k != {KW{1'b0}}) && (cfg_n != {NW{1'b0}});
  assign ch_go_s      = (state_r == OUT) && out_ready && !ch_last_s;
  assign elem_first_s = (elem_r == {KW{1'b0}});
  assign elem_last_s  = (elem_r == (cfg_k_r - KW'(1'b1)));

  pe_sched_addr_gen #(.KW(KW), .NW(NW)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .job_go     (job_go_s),
    .ch_go      (ch_go_s),
    .cfg_k      (cfg_k_r),
    .cfg_n      (cfg_n_r),
    .if_rd      (if_rd),
    .if_addr    (if_addr),
    .w_rd       (w_rd),
    .w_addr     (w_addr),
    .b_rd       (b_rd),
    .b_addr     (b_addr),
    .issue_last (issue_last_s),
    .ch_last    (ch_last_s)
  );

  // Next accumulator value; the first element of a channel replaces the sum.
  always_comb begin
    acc_next_s = acc_r;
    if (elem_first_s) begin
      acc_next_s = pe_opsum;
    end else begin
      acc_next_s = acc_r + pe_opsum;
    end
  end

`ifdef PE_DOT_SCHEDULER_RELU_EN
  assign load_val_s = acc_next_s[ACCW-1] ? {ACCW{1'b0}} : acc_next_s;
`else
  assign load_val_s = acc_next_s;
`endif

  // Operand stage: captures SRAM data the cycle it returns and feeds the PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_d_r      <= 1'b0;
      brd_d_r     <= 1'b0;
      pe_en_r     <= 1'b0;
      pe_ifmap_r  <= {OPW{1'b0}};
      pe_weight_r <= {OPW{1'b0}};
      pe_bias_r   <= {ACCW{1'b0}};
    end else begin
      rd_d_r      <= if_rd;
      brd_d_r     <= b_rd;
      pe_en_r     <= rd_d_r;
      pe_ifmap_r  <= rd_d_r  ? if_rdata : {OPW{1'b0}};
      pe_weight_r <= rd_d_r  ? w_rdata  : {OPW{1'b0}};
      pe_bias_r   <= brd_d_r ? b_rdata  : {ACCW{1'b0}};
    end
  end

  // Accumulator and per-channel element tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= {ACCW{1'b0}};
      elem_r <= {KW{1'b0}};
    end else if (job_go_s) begin
      elem_r <= {KW{1'b0}};
    end else if (pe_valid) begin
      acc_r  <= acc_next_s;
      elem_r <= elem_last_s ? {KW{1'b0}} : (elem_r + KW'(1'b1));
    end
  end

  // Job FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cfg_k_r     <= {KW{1'b0}};
      cfg_n_r     <= {NW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {ACCW{1'b0}};
      out_ch_r    <= {NW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (job_go_s) begin
            cfg_k_r <= cfg_k;
            cfg_n_r <= cfg_n;
            busy_r  <= 1'b1;
            state_r <= ISSUE;
          end else if (start) begin
            // Empty job: report completion without touching the SRAMs.
            done_r  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_last_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          // Load straight from the final accumulation to save a cycle.
          if (pe_valid && elem_last_s) begin
            out_data_r  <= load_val_s;
            out_ch_r    <= b_addr;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (ch_last_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= ISSUE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pe_en     = pe_en_r;
  assign pe_ifmap  = pe_ifmap_r;
  assign pe_weight = pe_weight_r;
  assign pe_bias   = pe_bias_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_pe_dot_scheduler.sv
// tb_pe_dot_scheduler
//   Directed bench for pe_dot_scheduler with behavioural SRAMs and a
//   1-cycle registered MAC+bias PE. Expected results are hand-computed.
`timescale 1ns/1ps
module tb_pe_dot_scheduler;
  import pe_sched_pkg::*;

  localparam int KW = 10;
  localparam int NW = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [KW-1:0]          cfg_k = '0;
  logic [NW-1:0]          cfg_n = '0;
  logic                   busy, done;
  logic                   if_rd, w_rd, b_rd;
  logic [KW-1:0]          if_addr;
  logic [KW+NW-1:0]       w_addr;
  logic [NW-1:0]          b_addr;
  logic signed [7:0]      if_rdata = '0, w_rdata = '0;
  logic signed [31:0]     b_rdata = '0;
  logic                   pe_en;
  logic signed [7:0]      pe_ifmap, pe_weight;
  logic signed [31:0]     pe_bias;
  logic signed [31:0]     pe_opsum = '0;
  logic                   pe_valid = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [31:0]     out_data;
  logic [NW-1:0]          out_ch;

  logic signed [7:0]      ifm [0:15];
  logic signed [7:0]      wm  [0:63];
  logic signed [31:0]     bm  [0:7];

  int tests_run    = 0;
  int tests_failed = 0;
  int rd_cnt       = 0;
  int wq[$];
  int bq[$];
  logic [31:0] exp_q[$];

  pe_dot_scheduler #(.KW(KW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .busy(busy), .done(done),
    .if_rd(if_rd), .if_addr(if_addr), .if_rdata(if_rdata),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .b_rd(b_rd), .b_addr(b_addr), .b_rdata(b_rdata),
    .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_weight(pe_weight), .pe_bias(pe_bias),
    .pe_opsum(pe_opsum), .pe_valid(pe_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  // SRAMs with 1-cycle read latency.
  always @(posedge clk) begin
    if (if_rd) if_rdata <= ifm[if_addr[3:0]];
    if (w_rd)  w_rdata  <= wm[w_addr[5:0]];
    if (b_rd)  b_rdata  <= bm[b_addr[2:0]];
  end

  // PE model: registered MAC + bias, reset by the same rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_opsum <= '0;
      pe_valid <= 1'b0;
    end else begin
      pe_valid <= pe_en;
      if (pe_en) pe_opsum <= pe_ifmap * pe_weight + pe_bias;
    end
  end

  // Read monitor.
  always @(negedge clk) begin
    if (if_rd) rd_cnt++;
    if (w_rd)  wq.push_back(int'(w_addr));
    if (b_rd)  bq.push_back(int'(b_addr));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setup_t1();
    for (int i = 0; i < 4; i++) begin
      ifm[i] = 8'(i + 1);
      wm[i]  = 8'(i + 5);
    end
    bm[0] = 32'sd10;
  endtask

  task automatic setup_t2();
    for (int i = 0; i < 3; i++) ifm[i] = -8'sd128;
    for (int i = 0; i < 9; i++) wm[i] = -8'sd128;
    bm[0] = 32'sd0;
    bm[1] = -32'sd1;
    bm[2] = 32'sd5;
  endtask

  // Run one job and check every channel result, latency and the done pulse.
  task automatic run_job(input int k, input int n, input bit stall, input bit mid_start);
    int cnt;
    logic [31:0] held;
    cfg_k = KW'(k);
    cfg_n = NW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    if (mid_start) begin
      check_eq("busy_after_start", {31'd0, busy}, 32'd1);
      cfg_k = KW'(2);
      cfg_n = NW'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 1;
    end
    for (int ch = 0; ch < n; ch++) begin
      while (!out_valid && cnt < 200) begin
        tick();
        cnt++;
      end
      if (!out_valid) begin
        check_eq("out_valid_timeout", 32'd0, 32'd1);
        return;
      end
      check_eq("latency", 32'(cnt), 32'(k + 3));
      held = out_data;
      if (stall) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
          check_eq("stall_data", out_data, held);
          check_eq("stall_no_rd", {31'd0, if_rd}, 32'd0);
        end
      end
      check_eq("out_data", out_data, exp_q[ch]);
      check_eq("out_ch", 32'(out_ch), 32'(ch));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      cnt = 0;
      if (ch == n - 1) begin
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("busy_clear", {31'd0, busy}, 32'd0);
        check_eq("valid_clear", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("done_low", {31'd0, done}, 32'd0);
      end else begin
        check_eq("done_mid", {31'd0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    int rd_before;
    #22;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_if_rd", {31'd0, if_rd}, 32'd0);
    check_eq("rst_w_addr", 32'(w_addr), 32'd0);
    check_eq("rst_pe_en", {31'd0, pe_en}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic single-channel dot product: 5+12+21+32+10 = 80.
    setup_t1();
    exp_q = {32'd80};
    run_job(4, 1, 1'b0, 1'b0);

    // Three channels of -128*-128*3 = 49152 plus biases 0, -1, 5.
    setup_t2();
    exp_q = {32'd49152, 32'd49151, 32'd49157};
    wq.delete();
    bq.delete();
    run_job(3, 3, 1'b0, 1'b0);
    check_eq("w_addr_count", 32'(wq.size()), 32'd9);
    for (int i = 0; i < wq.size() && i < 9; i++) check_eq("w_addr_seq", 32'(wq[i]), 32'(i));
    check_eq("b_addr_count", 32'(bq.size()), 32'd3);
    for (int i = 0; i < bq.size() && i < 3; i++) check_eq("b_addr_seq", 32'(bq[i]), 32'(i));

    // Same job under 5-cycle back-pressure per result.
    rd_before = rd_cnt;
    run_job(3, 3, 1'b1, 1'b0);
    check_eq("stall_rd_total", 32'(rd_cnt - rd_before), 32'd9);

    // Empty jobs: done next cycle, no reads, no outputs.
    rd_before = rd_cnt;
    cfg_k = KW'(0);
    cfg_n = NW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("k0_done", {31'd0, done}, 32'd1);
    check_eq("k0_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("k0_done_low", {31'd0, done}, 32'd0);
    cfg_k = KW'(3);
    cfg_n = NW'(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("n0_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("empty_no_valid", {31'd0, out_valid}, 32'd0);
    end
    check_eq("empty_no_reads", 32'(rd_cnt - rd_before), 32'd0);

    // Start pulsed mid-job is ignored.
    setup_t1();
    exp_q = {32'd80};
    run_job(4, 1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("midstart_no_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midstart_idle", {31'd0, busy}, 32'd0);

    // Wrap: 0x7FFFFFFF + 1*1 wraps to 0x80000000 (ReLU clamps to 0).
    ifm[0] = 8'sd1;
    wm[0]  = 8'sd1;
    bm[0]  = 32'sh7FFFFFFF;
`ifdef PE_DOT_SCHEDULER_RELU_EN
    exp_q = {32'h00000000};
`else
    exp_q = {32'h80000000};
`endif
    run_job(1, 1, 1'b0, 1'b0);

    // Reset during channel 1 issue, then a clean job from channel 0.
    setup_t2();
    cfg_k = KW'(3);
    cfg_n = NW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !out_valid; i++) tick();
    check_eq("rstjob_ch0_data", out_data, 32'd49152);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("rstjob_ch1_issue", {31'd0, if_rd}, 32'd1);
    check_eq("rstjob_ch1_b_addr", 32'(b_addr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_if_rd", {31'd0, if_rd}, 32'd0);
    check_eq("arst_b_addr", 32'(b_addr), 32'd0);
    check_eq("arst_w_addr", 32'(w_addr), 32'd0);
    check_eq("arst_pe_en", {31'd0, pe_en}, 32'd0);
    check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_state", 32'(dut.state_r), 32'(IDLE));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("arst_no_valid", {31'd0, out_valid}, 32'd0);
    setup_t1();
    exp_q = {32'd80};
    run_job(4, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
